unidad_carga_almacenamiento: RTL and testbench

Load/store unit that executes the data-memory access selected by the control unit's `memRead`, `memWrite` and store-size signals. It sits between the datapath's ALU address / register read data and a byte-wide data memory. It serialises word, halfword and byte accesses into one-byte transactions and returns the formatted load value. The datapath holds while `busy` is high.

---
 rtl/unidad_carga_almacenamiento_pkg.sv | 20 ++
 rtl/unidad_carga_almacenamiento_formateador.sv | 19 +
 rtl/unidad_carga_almacenamiento.sv | 184 ++++++++++++++++++
 tb/tb_unidad_carga_almacenamiento.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_carga_almacenamiento_pkg.sv
// Shared encodings for the load/store unit: load types, store sizes and FSM states.
package paquete_memoria;

    localparam logic [1:0] LD_W  = 2'b00;
    localparam logic [1:0] LD_B  = 2'b01;
    localparam logic [1:0] LD_BU = 2'b10;

    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_B = 2'b01;
    localparam logic [1:0] ST_H = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CAP   = 3'd2,
        STORE = 3'd3,
        FIN   = 3'd4
    } estado_t;

endpackage

// File: rtl/unidad_carga_almacenamiento_formateador.sv
// Turns the big-endian assembled load bytes into the register value for lw/lb/lbu.
module formateador_carga
    import paquete_memoria::*;
(
    input  logic [1:0]  ld_type,
    input  logic [31:0] raw,
    output logic [31:0] value
);

    always_comb begin
        value = raw;
        case (ld_type)
            LD_B:    value = {{24{raw[7]}}, raw[7:0]};
            LD_BU:   value = {24'h0, raw[7:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/unidad_carga_almacenamiento.sv
// Load/store unit: serialises word/half/byte accesses into one-byte memory transactions.
module unidad_carga_almacenamiento
    import paquete_memoria::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        memRead,
    input  logic              memWrite,
    input  logic [1:0]        st_size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    estado_t           state, state_n;
    logic [1:0]        k, k_n;
    logic [1:0]        last, last_n;
    logic [1:0]        ld_type, ld_type_n;
    logic [31:0]       sreg, sreg_n;
    logic [23:0]       asm_bytes, asm_bytes_n;
    logic              re_d;
    logic [31:0]       rdata_n;
    logic              busy_n, done_n, err_n, we_n, re_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n;
    logic [31:0]       formatted;
    logic              bad;
    logic [1:0]        req_last;
    logic [31:0]       aligned;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDR_W];

    formateador_carga u_formateador (
        .ld_type (ld_type),
        .raw     ({asm_bytes, mem_rdata}),
        .value   (formatted)
    );

    // Request decode: byte count, alignment check and store data left-justified so byte k is [31:24].
    always_comb begin
        bad      = 1'b0;
        req_last = 2'd0;
        aligned  = wdata;
        if (memWrite) begin
            case (st_size)
                ST_W:    begin req_last = 2'd3; bad = (addr[1:0] != 2'b00); aligned = wdata; end
                ST_H:    begin req_last = 2'd1; bad = addr[0]; aligned = {wdata[15:0], 16'h0}; end
                ST_B:    begin req_last = 2'd0; aligned = {wdata[7:0], 24'h0}; end
                default: bad = 1'b1;
            endcase
        end else begin
            case (memRead)
                LD_W:         begin req_last = 2'd3; bad = (addr[1:0] != 2'b00); end
                LD_B, LD_BU:  req_last = 2'd0;
                default:      bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        k_n         = k;
        last_n      = last;
        ld_type_n   = ld_type;
        sreg_n      = sreg;
        asm_bytes_n = asm_bytes;
        rdata_n     = rdata;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = 1'b0;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        we_n        = 1'b0;
        re_n        = 1'b0;
        case (state)
            IDLE, FIN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
                if (start) begin
                    if (bad) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                        err_n   = 1'b1;
                    end else begin
                        busy_n = 1'b1;
                        k_n    = 2'd0;
                        last_n = req_last;
                        addr_n = addr[ADDR_W-1:0];
                        if (memWrite) begin
                            state_n = STORE;
                            we_n    = 1'b1;
                            wdata_n = aligned[31:24];
                            sreg_n  = {aligned[23:0], 8'h0};
                        end else begin
                            state_n   = LOAD;
                            re_n      = 1'b1;
                            ld_type_n = memRead;
                        end
                    end
                end
            end
            LOAD: begin
                // Byte k-1 arrives while byte k is being issued.
                if (re_d) asm_bytes_n = {asm_bytes[15:0], mem_rdata};
                if (k == last) begin
                    state_n = CAP;
                end else begin
                    k_n    = k + 2'd1;
                    addr_n = mem_addr + ADDR_W'(1);
                    re_n   = 1'b1;
                end
            end
            CAP: begin
                rdata_n = formatted;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = FIN;
            end
            STORE: begin
                if (k == last) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    k_n     = k + 2'd1;
                    addr_n  = mem_addr + ADDR_W'(1);
                    we_n    = 1'b1;
                    wdata_n = sreg[31:24];
                    sreg_n  = {sreg[23:0], 8'h0};
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= 2'd0;
            last      <= 2'd0;
            ld_type   <= LD_W;
            sreg      <= 32'h0;
            asm_bytes <= 24'h0;
            re_d      <= 1'b0;
            rdata     <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            last      <= last_n;
            ld_type   <= ld_type_n;
            sreg      <= sreg_n;
            asm_bytes <= asm_bytes_n;
            re_d      <= mem_re;
            rdata     <= rdata_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
        end
    end

endmodule

// File: tb/tb_unidad_carga_almacenamiento.sv
// Directed vector bench for unidad_carga_almacenamiento with a byte-wide memory model.
module tb_unidad_carga_almacenamiento;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        memRead;
    logic              memWrite;
    logic [1:0]        st_size;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we, mem_re;
    logic [7:0]        mem_rdata = 8'h0;

    int n_checks = 0;
    int n_pass   = 0;
    int re_cnt   = 0;
    int we_cnt   = 0;

    logic [7:0]           mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W+7:0]    exp_q[$];

    typedef struct {
        logic        wr;
        logic [1:0]  rd;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
        logic        poke;
    } vec_t;

    vec_t vecs[19];

    unidad_carga_almacenamiento #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .st_size   (st_size),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model: synchronous write, read data valid the cycle after mem_re
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // scoreboard: every observed write must match the next expected {addr, byte}
    always @(negedge clk) begin
        if (mem_re) re_cnt++;
        if (mem_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+7:0] e;
                e = exp_q.pop_front();
                check("write_addr", {22'h0, mem_addr}, {22'h0, e[ADDR_W+7:8]});
                check("write_data", {24'h0, mem_wdata}, {24'h0, e[7:0]});
            end
        end
    end

    // driver: called away from the clock edge; start is sampled at the next posedge
    task automatic do_req(input vec_t v);
        int n, cyc, busy_seen, re0, we0;
        logic seen;
        n = v.wr ? ((v.sz == 2'b00) ? 4 : (v.sz == 2'b10) ? 2 : 1)
                 : ((v.rd == 2'b00) ? 4 : 1);
        if (v.exp_err) n = 0;
        if (v.wr)
            for (int k = 0; k < n; k++)
                exp_q.push_back({ADDR_W'(v.a[ADDR_W-1:0] + ADDR_W'(k)), v.wd[8*(n-1-k) +: 8]});
        re0 = re_cnt;
        we0 = we_cnt;
        start    = 1'b1;
        memWrite = v.wr;
        memRead  = v.rd;
        st_size  = v.sz;
        addr     = v.a;
        wdata    = v.wd;
        @(posedge clk);
        #1;
        start    = 1'b0;
        memWrite = ~v.wr;
        memRead  = 2'($urandom_range(0, 3));
        st_size  = 2'($urandom_range(0, 3));
        addr     = $urandom;
        wdata    = $urandom;
        seen = 1'b0;
        busy_seen = 0;
        cyc = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_seen++;
            if (v.poke && cyc == 2) begin
                start = 1'b1; memWrite = 1'b1; st_size = 2'b01; addr = 32'h50;
            end
            if (v.poke && cyc == 3) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'h0, seen}, 32'd1);
        check("done_cycle", cyc, v.exp_cyc);
        check("err", {31'h0, err}, {31'h0, v.exp_err});
        check("rdata", rdata, v.exp_rd);
        check("busy_cycles", busy_seen, v.exp_err ? 0 : v.exp_cyc - 1);
        check("re_strobes", re_cnt - re0, v.wr ? 0 : n);
        check("we_strobes", we_cnt - we0, v.wr ? n : 0);
    endtask

    initial begin
        int re0, we0, done_cnt;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h0;

        //          wr    rd     sz     addr           wdata          exp_rdata      err   cyc poke
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 5, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 2'b00, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b0, 6, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 2'b01, 32'h0000_0021, 32'h0000_00AB, 32'h1122_3344, 1'b0, 2, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 2'b00, 32'h0000_0021, 32'h0,         32'hFFFF_FFAB, 1'b0, 3, 1'b0};
        vecs[4]  = '{1'b0, 2'b10, 2'b00, 32'h0000_0021, 32'h0,         32'h0000_00AB, 1'b0, 3, 1'b0};
        vecs[5]  = '{1'b1, 2'b00, 2'b10, 32'h0000_0032, 32'h0000_BEEF, 32'h0000_00AB, 1'b0, 3, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 2'b10, 32'h0000_0033, 32'h0000_BEEF, 32'h0000_00AB, 1'b1, 1, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 2'b00, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b1, 1, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 2'b00, 32'h0000_0010, 32'h0,         32'h0000_00AB, 1'b1, 1, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 2'b11, 32'h0000_0040, 32'h5555_5555, 32'h0000_00AB, 1'b1, 1, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 2'b00, 32'h0000_0030, 32'h0,         32'h0000_BEEF, 1'b0, 6, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 2'b00, 32'h0000_0033, 32'h0,         32'hFFFF_FFEF, 1'b0, 3, 1'b0};
        vecs[12] = '{1'b0, 2'b00, 2'b00, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b0, 6, 1'b1};
        vecs[13] = '{1'b1, 2'b00, 2'b00, 32'h0000_07FC, 32'hDEAD_BEEF, 32'h1122_3344, 1'b0, 5, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 2'b00, 32'h0000_03FC, 32'h0,         32'hDEAD_BEEF, 1'b0, 6, 1'b0};
        vecs[15] = '{1'b0, 2'b10, 2'b00, 32'hFFFF_FFFF, 32'h0,         32'h0000_00EF, 1'b0, 3, 1'b0};
        vecs[16] = '{1'b0, 2'b01, 2'b00, 32'h0000_03FE, 32'h0,         32'hFFFF_FFBE, 1'b0, 3, 1'b0};
        vecs[17] = '{1'b1, 2'b00, 2'b10, 32'h0000_0100, 32'h1234_5678, 32'hFFFF_FFBE, 1'b0, 3, 1'b0};
        vecs[18] = '{1'b0, 2'b00, 2'b00, 32'h0000_0100, 32'h0,         32'h5678_0000, 1'b0, 6, 1'b0};

        // reset, then idle cycles with no strobes
        rst_n = 1'b0; start = 1'b0; memRead = 2'b00; memWrite = 1'b0;
        st_size = 2'b00; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_re", {31'h0, mem_re}, 32'h0);
        check("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
        re0 = re_cnt; we0 = we_cnt;
        repeat (3) @(negedge clk);
        check("idle_re", re_cnt - re0, 0);
        check("idle_we", we_cnt - we0, 0);
        check("idle_busy", {31'h0, busy}, 32'h0);

        // table: each request issued in the done cycle of the previous one
        for (int i = 0; i < 19; i++) do_req(vecs[i]);

        // reset in the middle of a word store
        exp_q.push_back({10'h060, 8'hCA});
        exp_q.push_back({10'h061, 8'hFE});
        start = 1'b1; memWrite = 1'b1; st_size = 2'b00; addr = 32'h60; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mem_we", {31'h0, mem_we}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_mem60", {24'h0, mem[10'h060]}, 32'hCA);
        check("midrst_mem61", {24'h0, mem[10'h061]}, 32'hFE);
        check("midrst_mem62", {24'h0, mem[10'h062]}, 32'h00);
        check("midrst_mem63", {24'h0, mem[10'h063]}, 32'h00);
        check("pending_writes", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
